// File: rtl/tnn_neuron_acc.sv
// Ternary-neuron accumulator: sums (pc_pos - pc_neg) over BEATS beats and emits a thresholded trit.
// Define TNN_ACC_SAT_EN to saturate each accumulation step; otherwise each step wraps.
module tnn_neuron_acc #(
   parameter int BEATS  = 4,
   parameter int ACC_W  = 8,
   parameter int THR_HI = 2,
   parameter int THR_LO = -2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       pc_pos,
   input  logic [4:0]       pc_neg,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_trit,
   output logic [ACC_W-1:0] out_sum
);

   localparam int CNT_W = $clog2(BEATS + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    valid_q, valid_d;
   logic [1:0]              trit_q, trit_d;
   logic [ACC_W-1:0]        sum_q, sum_d;

   logic signed [5:0]       diff;
   logic signed [ACC_W-1:0] acc_nxt;

   assign diff = {1'b0, pc_pos} - {1'b0, pc_neg};

`ifdef TNN_ACC_SAT_EN
   logic signed [ACC_W:0] sum_ext;

   // One guard bit: overflow shows up as disagreement between the top two bits.
   always_comb begin
      sum_ext = (ACC_W+1)'(acc_q) + (ACC_W+1)'(diff);
      if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
         acc_nxt = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
         acc_nxt = sum_ext[ACC_W-1:0];
      end
   end
`else
   always_comb begin
      acc_nxt = acc_q + ACC_W'(diff);
   end
`endif

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      trit_d  = trit_q;
      sum_d   = sum_q;
      if (flush) begin
         state_d = ST_ACC;
         acc_d   = '0;
         cnt_d   = '0;
         valid_d = 1'b0;
      end else if (state_q == ST_ACC) begin
         if (in_valid) begin
            if (cnt_q == LAST_BEAT) begin
               sum_d   = acc_nxt;
               if (int'(acc_nxt) > THR_HI) begin
                  trit_d = 2'b01;
               end else if (int'(acc_nxt) < THR_LO) begin
                  trit_d = 2'b11;
               end else begin
                  trit_d = 2'b00;
               end
               valid_d = 1'b1;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_HOLD;
            end else begin
               acc_d = acc_nxt;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end else begin
         if (out_ready) begin
            valid_d = 1'b0;
            state_d = ST_ACC;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_ACC;
         acc_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         trit_q  <= 2'b00;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         trit_q  <= trit_d;
         sum_q   <= sum_d;
      end
   end

   assign in_ready  = (state_q == ST_ACC);
   assign out_valid = valid_q;
   assign out_trit  = trit_q;
   assign out_sum   = sum_q;

endmodule

// File: tb/tb_tnn_neuron_acc.sv
// Scoreboard bench for tnn_neuron_acc (ACC_W=8 main instance, ACC_W=6 saturation/wrap instance).
module tb_tnn_neuron_acc;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [4:0] pc_pos = '0;
   logic [4:0] pc_neg = '0;
   logic       flush = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [1:0] out_trit;
   logic [7:0] out_sum;

   logic       s_in_valid = 1'b0;
   logic       s_in_ready;
   logic [4:0] s_pc_pos = '0;
   logic       s_out_valid;
   logic [1:0] s_out_trit;
   logic [5:0] s_out_sum;

   typedef struct {
      int         sum;
      logic [1:0] trit;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   acc_m = 0;
   int   cnt_m = 0;

   always #5 clk = ~clk;

   tnn_neuron_acc #(.BEATS(4), .ACC_W(8), .THR_HI(2), .THR_LO(-2)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .pc_pos(pc_pos), .pc_neg(pc_neg), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_trit(out_trit), .out_sum(out_sum)
   );

   tnn_neuron_acc #(.BEATS(4), .ACC_W(6), .THR_HI(2), .THR_LO(-2)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .pc_pos(s_pc_pos), .pc_neg(5'd0), .flush(1'b0), .out_valid(s_out_valid),
      .out_ready(1'b0), .out_trit(s_out_trit), .out_sum(s_out_sum)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic int step(input int acc, input int d, input int w);
      int v;
      v = acc + d;
`ifdef TNN_ACC_SAT_EN
      if (v > (1 << (w-1)) - 1) v = (1 << (w-1)) - 1;
      if (v < -(1 << (w-1))) v = -(1 << (w-1));
`else
      v = v & ((1 << w) - 1);
      if (v >= (1 << (w-1))) v = v - (1 << w);
`endif
      return v;
   endfunction

   function automatic logic [1:0] trit_of(input int s);
      if (s > 2) return 2'b01;
      if (s < -2) return 2'b11;
      return 2'b00;
   endfunction

   task automatic beat(input int p, input int n);
      int t;
      exp_t e;
      in_valid = 1'b1;
      pc_pos = 5'(p);
      pc_neg = 5'(n);
      t = 0;
      while (!in_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!in_ready) begin
         check_eq("beat_timeout", 32'(in_ready), 32'd1);
      end else begin
         @(posedge clk); #1;
         acc_m = step(acc_m, p - n, 8);
         cnt_m++;
         if (cnt_m == 4) begin
            e.sum = acc_m;
            e.trit = trit_of(acc_m);
            sb_q.push_back(e);
            acc_m = 0;
            cnt_m = 0;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int   t;
      exp_t e;
      out_ready = 1'b1;
      t = 0;
      while (!out_valid && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!out_valid) begin
         check_eq("out_timeout", 32'(out_valid), 32'd1);
      end else if (sb_q.size() == 0) begin
         check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         check_eq("sum", 32'(out_sum), 32'(e.sum[7:0]));
         check_eq("trit", 32'(out_trit), 32'(e.trit));
         @(posedge clk); #1;
         check_eq("valid_drop", 32'(out_valid), 32'd0);
         check_eq("ready_back", 32'(in_ready), 32'd1);
      end
      out_ready = 1'b0;
   endtask

   task automatic eval4(input int p0, n0, p1, n1, p2, n2, p3, n3);
      beat(p0, n0);
      beat(p1, n1);
      beat(p2, n2);
      beat(p3, n3);
      drain();
   endtask

   initial begin
      int thr_tab[4][2];
      int s_exp;
      exp_t e;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_sum", 32'(out_sum), 32'd0);
      check_eq("rst_trit", 32'(out_trit), 32'd0);
      check_eq("rst_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic evaluation: total 11 with latency check
      beat(10, 3); beat(5, 5); beat(0, 2); beat(7, 1);
      check_eq("valid_latency", 32'(out_valid), 32'd1);
      check_eq("hold_ready", 32'(in_ready), 32'd0);
      drain();

      // Threshold boundaries: totals 2, -3, -2, 3
      thr_tab = '{'{2, 0}, '{0, 3}, '{0, 2}, '{3, 0}};
      for (int i = 0; i < 4; i++) begin
         beat(thr_tab[i][0], thr_tab[i][1]);
         beat(0, 0); beat(0, 0); beat(0, 0);
         drain();
      end

      // Wide-range patterns
      eval4(31, 0, 31, 0, 31, 0, 31, 0);
      eval4(0, 31, 0, 31, 0, 31, 0, 31);
      eval4(17, 9, 4, 22, 31, 31, 12, 0);

      // Backpressure: result held, offered beat not consumed
      beat(20, 1); beat(3, 9); beat(31, 31); beat(0, 4);
      in_valid = 1'b1;
      pc_pos = 5'd31;
      pc_neg = 5'd0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         e = sb_q[0];
         check_eq("bp_valid", 32'(out_valid), 32'd1);
         check_eq("bp_sum", 32'(out_sum), 32'(e.sum[7:0]));
         check_eq("bp_trit", 32'(out_trit), 32'(e.trit));
         check_eq("bp_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      drain();
      eval4(1, 0, 1, 0, 1, 0, 0, 0);

      // Flush mid-evaluation drops the concurrent beat
      beat(30, 0); beat(30, 0);
      flush = 1'b1;
      in_valid = 1'b1;
      pc_pos = 5'd31;
      pc_neg = 5'd0;
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      acc_m = 0;
      cnt_m = 0;
      check_eq("flush_valid", 32'(out_valid), 32'd0);
      check_eq("flush_ready", 32'(in_ready), 32'd1);
      eval4(0, 1, 0, 1, 0, 1, 0, 0);

      // Flush in HOLD discards the pending result
      beat(9, 0); beat(0, 0); beat(0, 0); beat(0, 0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check_eq("hflush_valid", 32'(out_valid), 32'd0);
      check_eq("hflush_ready", 32'(in_ready), 32'd1);
      void'(sb_q.pop_back());
      eval4(5, 0, 5, 0, 0, 0, 0, 0);

      // Reset after 3 beats restarts the count
      beat(8, 0); beat(8, 0); beat(8, 0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      acc_m = 0;
      cnt_m = 0;
      check_eq("mrst_valid", 32'(out_valid), 32'd0);
      check_eq("mrst_sum", 32'(out_sum), 32'd0);
      check_eq("mrst_trit", 32'(out_trit), 32'd0);
      check_eq("mrst_ready", 32'(in_ready), 32'd1);
      eval4(0, 6, 1, 0, 1, 0, 1, 0);

      // ACC_W=6, four (31,0) beats: saturate or wrap depending on build
      s_exp = 0;
      for (int i = 0; i < 4; i++) s_exp = step(s_exp, 31, 6);
      s_in_valid = 1'b1;
      s_pc_pos = 5'd31;
      repeat (4) @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      check_eq("sat_valid", 32'(s_out_valid), 32'd1);
      check_eq("sat_sum", 32'(s_out_sum), 32'(s_exp[5:0]));
      check_eq("sat_trit", 32'(s_out_trit), 32'(trit_of(s_exp)));

      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
